// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache miss sequencer.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB,
        REFILL,
        FILL
    } state_t;

    localparam int unsigned BYTE_OFF   = 2;
    localparam int unsigned MAX_ADDR_W = 64;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Clears the word-index and byte-offset bits; idx_w is 0 for one-word lines.
    function automatic logic [MAX_ADDR_W-1:0] blk_base(input logic [MAX_ADDR_W-1:0] addr,
                                                       input int unsigned          idx_w);
        logic [MAX_ADDR_W-1:0] mask;
        mask = '1;
        mask = mask << (idx_w + BYTE_OFF);
        return addr & mask;
    endfunction

endpackage

// File: rtl/cache_word_seq.sv
// Word sequencer for line transfers: counts transactions k and produces the
// wrapped word index w = (s + k) mod BLK_WORDS.
module cache_word_seq
    import cache_pkg::*;
#(
    parameter int unsigned BLK_WORDS = 4,
    parameter int unsigned OFF_W     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             adv,
    input  logic [OFF_W-1:0] s_in,
    output logic [OFF_W-1:0] k,
    output logic [OFF_W-1:0] w,
    output logic             last
);

    localparam logic [OFF_W-1:0] K_LAST = OFF_W'(BLK_WORDS - 1);

    logic [OFF_W-1:0] k_q;
    logic [OFF_W-1:0] s_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q <= '0;
            s_q <= '0;
        end else if (start) begin
            k_q <= '0;
            s_q <= s_in;
        end else if (adv) begin
            k_q <= last ? '0 : k_q + OFF_W'(1);
        end
    end

    always_comb begin
        k    = k_q;
        last = (k_q == K_LAST);
        w    = (BLK_WORDS == 1) ? '0 : s_q + k_q;
    end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Cache miss sequencer: one-cycle hit lookup, dirty victim write-back, line refill, replay.
// Define CACHE_CWF_EN for critical-word-first refill order.
module cache_miss_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BLK_WORDS = 4
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ready,
    output logic              busy,
    input  logic              tag_hit,
    input  logic              victim_dirty,
    input  logic [ADDR_W-1:0] victim_addr,
    output logic [(clog2(BLK_WORDS) == 0 ? 1 : clog2(BLK_WORDS))-1:0] line_word,
    output logic              line_we,
    output logic              line_inval,
    output logic              line_fill,
    output logic              mark_dirty,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack
);

    localparam int unsigned IDX_W = clog2(BLK_WORDS);
    localparam int unsigned OFF_W = (IDX_W == 0) ? 1 : IDX_W;

    if (DATA_W != 32) begin : g_width_check
        $error("cache_miss_ctrl: DATA_W must be 32 to match the 2-bit byte offset");
    end

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [ADDR_W-1:0] vbase_q;
    logic              inval_q;

    logic [ADDR_W-1:0] lbase;
    logic [ADDR_W-1:0] vbase_in;
    logic [OFF_W-1:0]  refill_s;
    logic              seq_start;
    logic              seq_adv;
    logic [OFF_W-1:0]  seq_s;
    logic [OFF_W-1:0]  seq_k;
    logic [OFF_W-1:0]  seq_w;
    logic              seq_last;

    assign lbase    = ADDR_W'(blk_base(MAX_ADDR_W'(addr_q), IDX_W));
    assign vbase_in = ADDR_W'(blk_base(MAX_ADDR_W'(victim_addr), IDX_W));

`ifdef CACHE_CWF_EN
    assign refill_s = (BLK_WORDS == 1) ? '0 : addr_q[BYTE_OFF +: OFF_W];
`else
    assign refill_s = '0;
`endif

    cache_word_seq #(
        .BLK_WORDS (BLK_WORDS),
        .OFF_W     (OFF_W)
    ) u_seq (
        .clk   (CLK),
        .rst_n (CLR),
        .start (seq_start),
        .adv   (seq_adv),
        .s_in  (seq_s),
        .k     (seq_k),
        .w     (seq_w),
        .last  (seq_last)
    );

    // inval_q marks the first REFILL cycle so line_inval stays a registered decode.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state   <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            vbase_q <= '0;
            inval_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            inval_q <= (state_nxt == REFILL) && (state != REFILL);
            if (state == IDLE && cpu_req) begin
                addr_q <= cpu_addr;
                we_q   <= cpu_we;
            end
            if (state == LOOKUP && !tag_hit && victim_dirty) begin
                vbase_q <= vbase_in;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        cpu_ready  = 1'b0;
        mark_dirty = 1'b0;
        line_word  = '0;
        line_we    = 1'b0;
        line_inval = 1'b0;
        line_fill  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        seq_start  = 1'b0;
        seq_adv    = 1'b0;
        seq_s      = refill_s;

        case (state)
            IDLE: begin
                if (cpu_req) begin
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                if (tag_hit) begin
                    cpu_ready  = 1'b1;
                    mark_dirty = we_q;
                    state_nxt  = IDLE;
                end else begin
                    seq_start = 1'b1;
                    if (victim_dirty) begin
                        seq_s     = '0;
                        state_nxt = WB;
                    end else begin
                        state_nxt = REFILL;
                    end
                end
            end
            WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                line_word = seq_k;
                mem_addr  = vbase_q | ADDR_W'({seq_k, 2'b00});
                seq_adv   = mem_ack;
                if (mem_ack && seq_last) begin
                    seq_start = 1'b1;
                    state_nxt = REFILL;
                end
            end
            REFILL: begin
                mem_req    = 1'b1;
                line_word  = seq_w;
                mem_addr   = lbase | ADDR_W'({seq_w, 2'b00});
                line_we    = mem_ack;
                line_inval = inval_q;
                seq_adv    = mem_ack;
                if (mem_ack && seq_last) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                line_fill = 1'b1;
                state_nxt = LOOKUP;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl (BLK_WORDS=4); adapts refill order to CACHE_CWF_EN.
module tb_cache_miss_ctrl;

    logic        CLK;
    logic        CLR;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic        cpu_ready;
    logic        busy;
    logic        tag_hit;
    logic        victim_dirty;
    logic [31:0] victim_addr;
    logic [1:0]  line_word;
    logic        line_we;
    logic        line_inval;
    logic        line_fill;
    logic        mark_dirty;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic        mem_ack;

    int ntests = 0;
    int nfail  = 0;

    cache_miss_ctrl #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .BLK_WORDS (4)
    ) dut (
        .CLK          (CLK),
        .CLR          (CLR),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_ready    (cpu_ready),
        .busy         (busy),
        .tag_hit      (tag_hit),
        .victim_dirty (victim_dirty),
        .victim_addr  (victim_addr),
        .line_word    (line_word),
        .line_we      (line_we),
        .line_inval   (line_inval),
        .line_fill    (line_fill),
        .mark_dirty   (mark_dirty),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // IDLE cycle in which the request is sampled
    task automatic issue(input logic [31:0] a, input logic we);
        cpu_req      = 1'b1;
        cpu_addr     = a;
        cpu_we       = we;
        tag_hit      = 1'b0;
        victim_dirty = 1'b0;
        settle();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ready", 32'(cpu_ready), 32'd0);
        chk("idle_memreq", 32'(mem_req), 32'd0);
        cyc();
    endtask

    task automatic lookup_hit(input logic we);
        tag_hit = 1'b1;
        settle();
        chk("hit_busy", 32'(busy), 32'd1);
        chk("hit_ready", 32'(cpu_ready), 32'd1);
        chk("hit_dirty", 32'(mark_dirty), 32'(we));
        chk("hit_memreq", 32'(mem_req), 32'd0);
        chk("hit_fill", 32'(line_fill), 32'd0);
        cyc();
        cpu_req = 1'b0;
        tag_hit = 1'b0;
        settle();
        chk("post_ready", 32'(cpu_ready), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        cyc();
    endtask

    task automatic lookup_miss(input logic dirty, input logic [31:0] va);
        tag_hit      = 1'b0;
        victim_dirty = dirty;
        victim_addr  = va;
        settle();
        chk("miss_ready", 32'(cpu_ready), 32'd0);
        chk("miss_dirty", 32'(mark_dirty), 32'd0);
        chk("miss_memreq", 32'(mem_req), 32'd0);
        cyc();
        victim_dirty = 1'b0;
        victim_addr  = 32'h0;
    endtask

    task automatic phase(input logic wr, input logic [31:0] base, input int first,
                         input int waits, input logic inval_first, input int nwords);
        int          widx;
        logic [31:0] ea;
        logic        exp_we;
        logic        exp_inv;
        for (int k = 0; k < nwords; k++) begin
            widx = (first + k) % 4;
            ea   = base + 32'(widx * 4);
            for (int d = 0; d <= waits; d++) begin
                mem_ack = (d == waits);
                exp_we  = !wr && (d == waits);
                exp_inv = inval_first && (k == 0) && (d == 0);
                settle();
                chk("mem_req", 32'(mem_req), 32'd1);
                chk("mem_we", 32'(mem_we), 32'(wr));
                chk("mem_addr", mem_addr, ea);
                chk("line_word", 32'(line_word), 32'(widx));
                chk("line_we", 32'(line_we), 32'(exp_we));
                chk("line_inval", 32'(line_inval), 32'(exp_inv));
                chk("line_fill_xfer", 32'(line_fill), 32'd0);
                cyc();
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic fill();
        settle();
        chk("fill", 32'(line_fill), 32'd1);
        chk("fill_memreq", 32'(mem_req), 32'd0);
        chk("fill_ready", 32'(cpu_ready), 32'd0);
        chk("fill_inval", 32'(line_inval), 32'd0);
        cyc();
    endtask

    int cwf_first;

    initial begin
        CLR          = 1'b0;
        cpu_req      = 1'b0;
        cpu_we       = 1'b0;
        cpu_addr     = 32'h0;
        tag_hit      = 1'b0;
        victim_dirty = 1'b0;
        victim_addr  = 32'h0;
        mem_ack      = 1'b0;
`ifdef CACHE_CWF_EN
        cwf_first = 2;
`else
        cwf_first = 0;
`endif

        // Reset state
        repeat (2) cyc();
        settle();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_memreq", 32'(mem_req), 32'd0);
        chk("rst_memaddr", mem_addr, 32'h0);
        chk("rst_ready", 32'(cpu_ready), 32'd0);
        CLR = 1'b1;
        cyc();

        // 1: load hit, ready the cycle after sampling
        issue(32'h40, 1'b0);
        lookup_hit(1'b0);

        // 2: clean miss, ack two cycles after req
        issue(32'h40, 1'b0);
        lookup_miss(1'b0, 32'h0);
        phase(1'b0, 32'h40, 0, 2, 1'b1, 4);
        fill();
        lookup_hit(1'b0);

        // 3: dirty miss, write-back then refill
        issue(32'h2044, 1'b0);
        lookup_miss(1'b1, 32'h1000);
        phase(1'b1, 32'h1000, 0, 1, 1'b0, 4);
        phase(1'b0, 32'h2040, 0, 1, 1'b1, 4);
        fill();
        lookup_hit(1'b0);

        // 4: miss at 0x48 with zero-wait RAM, order depends on CWF
        issue(32'h48, 1'b0);
        lookup_miss(1'b0, 32'h0);
        phase(1'b0, 32'h40, cwf_first, 0, 1'b1, 4);
        fill();
        lookup_hit(1'b0);

        // 5: store miss sets dirty on replay, then a store hit
        issue(32'h80, 1'b1);
        lookup_miss(1'b0, 32'h0);
        phase(1'b0, 32'h80, 0, 0, 1'b1, 4);
        fill();
        lookup_hit(1'b1);
        issue(32'h84, 1'b1);
        lookup_hit(1'b1);

        // 6: reset during refill word 2
        issue(32'h100, 1'b0);
        lookup_miss(1'b0, 32'h0);
        phase(1'b0, 32'h100, 0, 0, 1'b1, 2);
        settle();
        chk("pre_rst_memreq", 32'(mem_req), 32'd1);
        chk("pre_rst_addr", mem_addr, 32'h108);
        #1;
        CLR     = 1'b0;
        cpu_req = 1'b0;
        #1;
        chk("rst_mid_memreq", 32'(mem_req), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_fill", 32'(line_fill), 32'd0);
        chk("rst_mid_we", 32'(line_we), 32'd0);
        cyc();
        settle();
        chk("rst_hold_fill", 32'(line_fill), 32'd0);
        chk("rst_hold_memreq", 32'(mem_req), 32'd0);
        CLR = 1'b1;
        cyc();
        issue(32'h100, 1'b0);
        lookup_miss(1'b0, 32'h0);
        phase(1'b0, 32'h100, 0, 1, 1'b1, 4);
        fill();
        lookup_hit(1'b0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
